// File: rtl/sram_echo_delay.sv
// Feedback echo with a circular sample buffer in external async SRAM. Optional wb saturation:
// define ECHO_SATURATE_EN to clamp the write-back sample instead of wrapping it.
module sram_echo_delay #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned DEPTH   = 2**20,
  parameter int unsigned RD_WAIT = 2
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] input_frame,
  input  logic [ADDR_W-1:0]        delay_len,
  input  logic [3:0]               fb_gain,
  input  logic [4:0]               mix,
  output logic signed [DATA_W-1:0] output_frame,
  output logic                     out_valid,
  output logic [ADDR_W-1:0]        SRAM_ADDR,
  inout  wire  [DATA_W-1:0]        SRAM_DQ,
  output logic                     SRAM_CE_N,
  output logic                     SRAM_OE_N,
  output logic                     SRAM_WE_N
);

  localparam int unsigned WA  = DATA_W + 7;
  localparam int unsigned WCW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [ADDR_W-1:0] AddrMax  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FillMax  = (ADDR_W+1)'(DEPTH);
  localparam logic [WCW-1:0]    WaitLast = WCW'(RD_WAIT - 1);

  typedef enum logic [2:0] {StIdle, StRd, StRdWait, StMix, StWr, StWrEnd} state_e;

  state_e                    state_q, state_d;
  logic [WCW-1:0]            wait_q;
  logic [ADDR_W-1:0]         wr_ptr_q, rd_ptr_q, d_q;
  logic [ADDR_W:0]           fill_q;
  logic signed [DATA_W-1:0]  dry_q, wet_q, wb_q, out_q;
  logic [3:0]                fb_q;
  logic [4:0]                mix_q;
  logic                      out_valid_q;

  logic                      accept;
  logic [ADDR_W-1:0]         d_clamp, rd_start;
  logic signed [DATA_W-1:0]  wet_sample, out_new, wb_new;
  logic signed [WA-1:0]      dry_x, wet_x, mix_x, inv_x, fb_x, mix_sum, fb_term, wb_full;

  assign accept = in_valid && (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (in_valid) state_d = StRd;
      StRd:     state_d = StRdWait;
      StRdWait: if (wait_q == WaitLast) state_d = StMix;
      StMix:    state_d = StWr;
      StWr:     state_d = StWrEnd;
      StWrEnd:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    if (delay_len == '0) begin
      d_clamp = ADDR_W'(1);
    end else if (delay_len > AddrMax) begin
      d_clamp = AddrMax;
    end else begin
      d_clamp = delay_len;
    end
    // Modular subtraction; DEPTH need not be a power of two.
    if (wr_ptr_q >= d_clamp) begin
      rd_start = wr_ptr_q - d_clamp;
    end else begin
      rd_start = ADDR_W'({1'b0, wr_ptr_q} + FillMax - {1'b0, d_clamp});
    end
  end

  // Words older than the number of samples written so far were never written: read as silence.
  assign wet_sample = (fill_q < {1'b0, d_q}) ? '0 : $signed(SRAM_DQ);

  always_comb begin
    dry_x   = {{(WA-DATA_W){dry_q[DATA_W-1]}}, dry_q};
    wet_x   = {{(WA-DATA_W){wet_q[DATA_W-1]}}, wet_q};
    mix_x   = {{(WA-5){1'b0}}, mix_q};
    inv_x   = WA'(16) - mix_x;
    fb_x    = {{(WA-4){1'b0}}, fb_q};
    mix_sum = dry_x * inv_x + wet_x * mix_x;
    fb_term = (wet_x * fb_x) >>> 4;
    wb_full = dry_x + fb_term;
    out_new = DATA_W'(mix_sum >>> 4);
`ifdef ECHO_SATURATE_EN
    if (wb_full > $signed({{(WA-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}})) begin
      wb_new = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (wb_full < $signed({{(WA-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}})) begin
      wb_new = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      wb_new = DATA_W'(wb_full);
    end
`else
    wb_new = DATA_W'(wb_full);
`endif
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      d_q         <= '0;
      fill_q      <= '0;
      dry_q       <= '0;
      wet_q       <= '0;
      wb_q        <= '0;
      out_q       <= '0;
      fb_q        <= '0;
      mix_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_q == StMix);
      if (accept) begin
        dry_q    <= input_frame;
        fb_q     <= fb_gain;
        mix_q    <= (mix > 5'd16) ? 5'd16 : mix;
        d_q      <= d_clamp;
        rd_ptr_q <= rd_start;
      end
      if (state_q == StRd) begin
        wait_q <= '0;
      end else if (state_q == StRdWait) begin
        wait_q <= wait_q + WCW'(1);
      end
      if (state_q == StRdWait && wait_q == WaitLast) begin
        wet_q <= wet_sample;
      end
      if (state_q == StMix) begin
        out_q <= out_new;
        wb_q  <= wb_new;
      end
      if (state_q == StWrEnd) begin
        wr_ptr_q <= (wr_ptr_q == AddrMax) ? '0 : wr_ptr_q + ADDR_W'(1);
        fill_q   <= (fill_q == FillMax) ? fill_q : fill_q + (ADDR_W+1)'(1);
      end
    end
  end

  assign in_ready     = (state_q == StIdle);
  assign output_frame = out_q;
  assign out_valid    = out_valid_q;
  assign SRAM_CE_N    = (state_q == StIdle);
  assign SRAM_OE_N    = !(state_q == StRd || state_q == StRdWait);
  assign SRAM_WE_N    = (state_q != StWr);
  assign SRAM_ADDR    = (state_q == StRd || state_q == StRdWait) ? rd_ptr_q : wr_ptr_q;
  assign SRAM_DQ      = (state_q == StWr || state_q == StWrEnd) ? wb_q : 'z;

endmodule

// File: tb/tb_sram_echo_delay.sv
// Directed bench for sram_echo_delay with DEPTH=16, RD_WAIT=2 and a behavioural async SRAM.
module tb_sram_echo_delay;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] input_frame = '0;
  logic [19:0]        delay_len = '0;
  logic [3:0]         fb_gain = '0;
  logic [4:0]         mix = '0;
  logic signed [15:0] output_frame;
  logic               out_valid;
  logic [19:0]        sram_addr;
  wire  [15:0]        sram_dq;
  logic               sram_ce_n, sram_oe_n, sram_we_n;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ECHO_SATURATE_EN
  localparam int ExpWb1 = 32767;
  localparam int ExpWb2 = 32767;
`else
  localparam int ExpWb1 = -7411;
  localparam int ExpWb2 = 23052;
`endif

  always #5 clk = ~clk;

  sram_echo_delay #(
    .DATA_W (16),
    .ADDR_W (20),
    .DEPTH  (16),
    .RD_WAIT(2)
  ) dut (
    .CLK         (clk),
    .RESET_N     (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .input_frame (input_frame),
    .delay_len   (delay_len),
    .fb_gain     (fb_gain),
    .mix         (mix),
    .output_frame(output_frame),
    .out_valid   (out_valid),
    .SRAM_ADDR   (sram_addr),
    .SRAM_DQ     (sram_dq),
    .SRAM_CE_N   (sram_ce_n),
    .SRAM_OE_N   (sram_oe_n),
    .SRAM_WE_N   (sram_we_n)
  );

  // Async SRAM: garbage power-up contents, combinational read, write captured while WE_N low.
  logic [15:0] mem [16] = '{default: 16'h5A5A};
  assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr[3:0]] : 'z;
  always @(posedge clk) if (!sram_ce_n && !sram_we_n) mem[sram_addr[3:0]] <= sram_dq;

  task automatic apply_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int din, input int dl, input int fb, input int mx,
                      output int dout, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    input_frame = 16'(din);
    delay_len   = 20'(dl);
    fb_gain     = 4'(fb);
    mix         = 5'(mx);
    in_valid    = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 50);
    dout = int'(output_frame);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL out_valid_timeout: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({in_ready, out_valid, sram_ce_n, sram_oe_n, sram_we_n} !== 5'b10111) begin
      n_fail++;
      $display("FAIL reset_ctrl: {rdy,ov,ce,oe,we}=%b, required 10111",
               {in_ready, out_valid, sram_ce_n, sram_oe_n, sram_we_n});
    end
    n_checks++;
    if (output_frame !== 16'sd0 || sram_addr !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_data: out=%0d addr=%0d, required 0 0", output_frame, sram_addr);
    end
  endtask

  task automatic test_impulse();
    int exp_o [6] = '{0, 0, 0, 0, 1000, 0};
    int o, lat;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      send((k == 0) ? 1000 : 0, 4, 0, 16, o, lat);
      n_checks++;
      if (o !== exp_o[k]) begin
        n_fail++;
        $display("FAIL impulse[%0d]: out=%0d, required %0d", k, o, exp_o[k]);
      end
      n_checks++;
      if (lat !== 4) begin
        n_fail++;
        $display("FAIL impulse_latency[%0d]: %0d cycles, required 4", k, lat);
      end
    end
  endtask

  task automatic test_feedback();
    int o, lat, e;
    apply_reset();
    for (int k = 0; k < 17; k++) begin
      send((k == 0) ? 1000 : 0, 4, 8, 16, o, lat);
      e = (k == 4) ? 1000 : (k == 8) ? 500 : (k == 12) ? 250 : (k == 16) ? 125 : 0;
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL feedback[%0d]: out=%0d, required %0d", k, o, e);
      end
    end
  endtask

  task automatic test_mix();
    int din [5]   = '{800, 800, 100, -7, 0};
    int mx [5]    = '{8, 8, 20, 0, 8};
    int dl [5]    = '{1, 1, 1, 0, 0};
    int exp_o [5] = '{400, 800, 800, -7, -4};
    int o, lat;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      send(din[k], dl[k], 0, mx[k], o, lat);
      n_checks++;
      if (o !== exp_o[k]) begin
        n_fail++;
        $display("FAIL mix[%0d]: out=%0d, required %0d", k, o, exp_o[k]);
      end
    end
  endtask

  task automatic test_saturate();
    int o, lat;
    apply_reset();
    send(30000, 1, 15, 0, o, lat);
    send(30000, 1, 15, 0, o, lat);
    n_checks++;
    if (o !== 30000) begin
      n_fail++;
      $display("FAIL sat_dry: out=%0d, required 30000", o);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ($signed(mem[1]) !== 16'(ExpWb1)) begin
      n_fail++;
      $display("FAIL sat_wb1: sram[1]=%0d, required %0d", $signed(mem[1]), ExpWb1);
    end
    send(30000, 1, 15, 16, o, lat);
    n_checks++;
    if (o !== ExpWb1) begin
      n_fail++;
      $display("FAIL sat_wet: out=%0d, required %0d", o, ExpWb1);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ($signed(mem[2]) !== 16'(ExpWb2)) begin
      n_fail++;
      $display("FAIL sat_wb2: sram[2]=%0d, required %0d", $signed(mem[2]), ExpWb2);
    end
  endtask

  task automatic test_wrap();
    int o, lat, e;
    apply_reset();
    for (int k = 0; k < 40; k++) begin
      // Second half uses an over-long delay that must clamp to DEPTH-1.
      send(100 + k, (k < 20) ? 15 : 1000, 0, 16, o, lat);
      e = (k >= 15) ? 100 + k - 15 : 0;
      n_checks++;
      if (o !== e || lat !== 4) begin
        n_fail++;
        $display("FAIL wrap[%0d]: out=%0d lat=%0d, required %0d lat=4", k, o, lat, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    apply_reset();
    input_frame = 16'sd500;
    delay_len   = 20'd1;
    fb_gain     = 4'd0;
    mix         = 5'd16;
    in_valid    = 1'b1;
    pulses = 0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
      if (c == 0) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_ready: in_ready=%0b, required 0", in_ready);
        end
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (pulses !== 10) begin
      n_fail++;
      $display("FAIL throughput: %0d outputs in 70 cycles, required 10", pulses);
    end
    n_checks++;
    if (output_frame !== 16'sd500) begin
      n_fail++;
      $display("FAIL b2b_last: out=%0d, required 500", output_frame);
    end
  endtask

  task automatic test_reset_mid();
    int o, lat, n;
    apply_reset();
    send(1234, 1, 0, 16, o, lat);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    input_frame = 16'sd555;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (sram_oe_n !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_read: oe_n=%0b, required 0", sram_oe_n);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, sram_ce_n, sram_oe_n, sram_we_n, out_valid} !== 5'b11110) begin
      n_fail++;
      $display("FAIL mid_reset: {rdy,ce,oe,we,ov}=%b, required 11110",
               {in_ready, sram_ce_n, sram_oe_n, sram_we_n, out_valid});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(700, 1, 0, 16, o, lat);
    n_checks++;
    if (o !== 0) begin
      n_fail++;
      $display("FAIL mid_fill_restart: out=%0d, required 0", o);
    end
    send(0, 1, 0, 16, o, lat);
    n_checks++;
    if (o !== 700) begin
      n_fail++;
      $display("FAIL mid_after: out=%0d, required 700", o);
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_feedback();
    test_mix();
    test_saturate();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
